seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector for the sequence-detector family. It generalises the fixed 10101 Mealy/Moore detectors to:
- any pattern length and value;
- compile-time Mealy or Moore output;
- run-time overlap or non-overlap matching;
- input qualification with a valid strobe;
- a saturating match counter.

It sits on a 1-bit serial input stream and flags each occurrence of PATTERN.

## Interface
- N, 5: pattern length in bits; legal range 2..32.
- PATTERN, 5'b10101: N-bit target. MSB is the first bit received.
- MOORE, 0: 0 = Mealy (combinational `out`), 1 = Moore (registered `out`).
- CNT_W, 8: width of the match counter.

- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- i  in  1  serial data bit.
- in_valid  in  1  `i` is sampled only on edges where this is 1.
- overlap_en  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- clr_cnt  in  1  synchronous clear of `match_cnt`.
- out  out  1  match indication, one cycle wide per match.
- match_cnt  out  CNT_W  number of matches since reset or last clear; saturating.

## Operation
- **State registers**
  - hist[N-2:0]: last N-1 accepted bits, newest bit in the LSB.
  - fill: count of accepted bits, saturating at N-1.
  - out_q: Moore output register, used only when MOORE=1.
  - match_cnt.
- **Hit (combinational)**: hit = in_valid && (fill == N-1) && ({hist, i} == PATTERN).
- **Clock edge with in_valid=1**
  - hist shifts left, with `i` entering the LSB.
  - fill increments, saturating at N-1.
  - Exception: if hit && !overlap_en, then fill <= 0 and hist <= 0. The matched bits are discarded.
- **Clock edge with in_valid=0**: hist and fill hold. Invalid cycles are invisible to matching.
- **overlap_en** is sampled only at the hit edge. Changing it between hits is legal.
- **Mealy (MOORE=0)**: out = hit. It is high during the cycle in which the final pattern bit is presented.
- **Moore (MOORE=1)**: out_q <= hit, so out = out_q. It is high for exactly the one cycle after the accepting edge.
- **Counter**
  - clr_cnt=1: match_cnt <= 0. This wins over a simultaneous hit; that hit is not counted, but `out` still fires.
  - Otherwise, on hit: match_cnt increments and holds at 2^CNT_W-1.
- **Reset (rst=0)**
  - Asynchronously forces hist=0, fill=0, out_q=0, match_cnt=0.
  - Because fill=0 forces hit=0, Mealy `out` is also 0 while in reset.
  - Reset mid-pattern discards all partial history.
- **Reset values**: out=0, match_cnt=0.

## Timing
- Mealy latency is 0 cycles from the last pattern bit; `out` is combinational from `i` and `in_valid`.
- Moore latency is 1 cycle; `out` is glitch-free, straight from a flop.
- match_cnt updates on the accepting edge in both modes. It is visible in the cycle after the last bit, so in Moore mode it changes together with `out`.
- Back-to-back matches:
  - Overlap mode: minimum spacing is the pattern's shortest self-overlap period (2 accepted bits for 10101).
  - Non-overlap mode: minimum spacing is N accepted bits.
  - Consecutive-cycle hits produce consecutive-cycle `out` pulses, with no merging.
- The first possible hit is on the N-th accepted bit after reset or after a non-overlap match.
- Release rst synchronously to clk at the bench; rst assertion may be at any time.

## Test plan
- **Overlap, MOORE=0, default pattern.** Stream 1,0,1,0,1,0,1 with in_valid=1 and overlap_en=1 → `out` is high on bit 5 and bit 7 only; match_cnt ends at 2.
- **Overlap, MOORE=1.** Same stream → `out` is high in the cycle after bit 5 and after bit 7, each for one cycle; match_cnt=2.
- **Non-overlap.** overlap_en=0, stream 1,0,1,0,1,0,1,0,1 → hit on bit 5 only. The remaining 0,1,0,1 does not form a full pattern, so no hit; match_cnt=1. Appending bit 1 (stream …0,1,0,1,1) gives no hit, because the accepted bits are 0101 followed by 1, not 10101.
- **Valid gaps.** Bits 1,0,1,0,1 with in_valid=0 cycles (carrying i=0) between every bit → exactly one hit, on the final valid 1; gap cycles never assert `out`.
- **Reset mid-pattern.** Send 1,0,1,0, pulse rst low for 15 ns between edges, then send 1 → no hit and match_cnt=0. Then send 0,1,0,1 → still no hit; a fifth bit 1 hits.
- **Saturation and clear.** CNT_W=2, drive 5 overlapping matches → match_cnt saturates at 3. Assert clr_cnt on the same edge as the 6th hit → match_cnt=0 and `out` still pulses.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector for an N-bit PATTERN (MSB
// received first). Mealy or Moore output is chosen at elaboration time.
// Overlapping matches are enabled at run time. A saturating counter keeps
// the number of matches seen.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   i          serial data bit
//   in_valid   i is accepted only on edges where this is 1
//   overlap_en 1: matches may share bits; 0: history restarts after a match
//   clr_cnt    synchronous clear of match_cnt (wins over a same-edge hit)
//   out        one-cycle match pulse (combinational if Mealy, flop if Moore)
//   match_cnt  matches since reset or last clear, saturating
module seq_detect_param #(
    parameter int             N       = 5,
    parameter logic [N-1:0]   PATTERN = 5'b10101,
    parameter bit             MOORE   = 1'b0,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             in_valid,
    input  logic             overlap_en,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    // fill only needs to reach N-1
    localparam int               FW       = $clog2(N);
    localparam logic [FW-1:0]    FILL_MAX = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [N-2:0]  hist;    // last N-1 accepted bits, newest in LSB
    logic [FW-1:0] fill;    // accepted bits held in hist, saturating
    logic [N-1:0]  window;  // hist plus the bit on the wire this cycle
    logic          hit;

    assign window = {hist, i};
    // fill gate stops a stale or reset-zero history from matching a
    // pattern whose leading bits are zero
    assign hit    = in_valid && (fill == FILL_MAX) && (window == PATTERN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            if (hit && !overlap_en) begin
                // the matched bits are consumed and cannot start a new match
                hist <= '0;
                fill <= '0;
            end else begin
                // dropping window's MSB is a left shift with i entering the
                // LSB, and holds for N=2 where hist is a single bit
                hist <= window[N-2:0];
                if (fill != FILL_MAX)
                    fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            match_cnt <= '0;
        else if (clr_cnt)
            match_cnt <= '0;
        else if (hit && match_cnt != CNT_MAX)
            match_cnt <= match_cnt + 1'b1;
    end

    generate
        if (MOORE) begin : g_moore
            logic out_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    out_q <= 1'b0;
                else
                    out_q <= hit;
            end
            assign out = out_q;
        end else begin : g_mealy
            assign out = hit;
        end
    endgenerate

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a Mealy/8-bit-counter instance, a Moore
// instance and a Mealy/2-bit-counter instance share one stimulus stream.
// A window-of-bits model is checked against all three on every falling
// edge, and directed pulse masks and counts pin the model itself.
module tb_seq_detect_param;

    localparam int         N = 5;
    localparam logic [4:0] P = 5'b10101;

    logic clk = 1'b0;
    logic rst, i, in_valid, overlap_en, clr_cnt;
    logic out0, out1, out2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    always #10 clk = ~clk;

    seq_detect_param #(.N(N), .PATTERN(P), .MOORE(1'b0), .CNT_W(8)) u_mealy (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .overlap_en(overlap_en),
        .clr_cnt(clr_cnt), .out(out0), .match_cnt(cnt0));
    seq_detect_param #(.N(N), .PATTERN(P), .MOORE(1'b1), .CNT_W(8)) u_moore (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .overlap_en(overlap_en),
        .clr_cnt(clr_cnt), .out(out1), .match_cnt(cnt1));
    seq_detect_param #(.N(N), .PATTERN(P), .MOORE(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .overlap_en(overlap_en),
        .clr_cnt(clr_cnt), .out(out2), .match_cnt(cnt2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // acc holds the accepted bits since the last restart, oldest first,
    // trimmed to the N-1 most recent.
    bit acc[$];
    int c8 = 0, c2 = 0;
    bit mq = 1'b0;

    function automatic bit model_hit();
        if (rst !== 1'b1 || in_valid !== 1'b1) return 1'b0;
        if (acc.size() < N - 1) return 1'b0;
        for (int j = 0; j < N - 1; j++)
            if (acc[acc.size() - (N - 1) + j] != P[N-1-j]) return 1'b0;
        return (i == P[0]);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc.delete();
            c8 <= 0;
            c2 <= 0;
            mq <= 1'b0;
        end else begin
            bit h;
            h = model_hit();
            mq <= h;
            if (clr_cnt) begin
                c8 <= 0;
                c2 <= 0;
            end else if (h) begin
                c8 <= (c8 < 255) ? c8 + 1 : 255;
                c2 <= (c2 < 3) ? c2 + 1 : 3;
            end
            if (in_valid) begin
                if (h && !overlap_en) acc.delete();
                else begin
                    acc.push_back(i);
                    if (acc.size() > N - 1) void'(acc.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        bit eh;
        eh = model_hit();
        chk("mealy_out", 32'(out0), 32'(eh));
        chk("mealy_out_w2", 32'(out2), 32'(eh));
        chk("moore_out", 32'(out1), 32'(mq));
        chk("cnt_mealy", 32'(cnt0), 32'(c8));
        chk("cnt_moore", 32'(cnt1), 32'(c8));
        chk("cnt_sat", 32'(cnt2), 32'(c2));
    end

    // ---------------- stimulus ----------------
    logic [15:0] m0, m1;   // per-step out samples, first step ends up in the MSB

    task automatic step(input logic b, input logic v);
        i = b;
        in_valid = v;
        @(negedge clk);
        m0 = {m0[14:0], out0};
        m1 = {m1[14:0], out1};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i = 1'b0;
        in_valid = 1'b0;
        clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m0 = '0;
        m1 = '0;
    endtask

    initial begin
        rst = 1'b0;
        i = 1'b0;
        in_valid = 1'b0;
        overlap_en = 1'b1;
        clr_cnt = 1'b0;
        m0 = '0;
        m1 = '0;
        #5;
        chk("reset_out_mealy", 32'(out0), 0);
        chk("reset_out_moore", 32'(out1), 0);
        chk("reset_cnt", 32'(cnt0), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // overlap, both output styles
        do_reset();
        overlap_en = 1'b1;
        step(1, 1); step(0, 1); step(1, 1); step(0, 1);
        step(1, 1); step(0, 1); step(1, 1); step(0, 0);
        chk("ovl_mealy_mask", 32'(m0[7:0]), 32'(8'b00001010));
        chk("ovl_moore_mask", 32'(m1[7:0]), 32'(8'b00000101));
        chk("ovl_cnt_mealy", 32'(cnt0), 2);
        chk("ovl_cnt_moore", 32'(cnt1), 2);

        // non-overlap: only the first match, trailing 0101,1 is not 10101
        do_reset();
        overlap_en = 1'b0;
        step(1, 1); step(0, 1); step(1, 1); step(0, 1); step(1, 1);
        step(0, 1); step(1, 1); step(0, 1); step(1, 1); step(1, 1);
        chk("novl_mask", 32'(m0[9:0]), 32'(10'b0000100000));
        chk("novl_cnt", 32'(cnt0), 1);

        // invalid gaps carrying i=0 are invisible
        do_reset();
        overlap_en = 1'b1;
        step(1, 1); step(0, 0); step(0, 1); step(0, 0); step(1, 1);
        step(0, 0); step(0, 1); step(0, 0); step(1, 1); step(0, 0);
        chk("gap_mealy_mask", 32'(m0[9:0]), 32'(10'b0000000010));
        chk("gap_moore_mask", 32'(m1[9:0]), 32'(10'b0000000001));
        chk("gap_cnt", 32'(cnt0), 1);

        // reset pulse mid-pattern drops the partial 1010
        do_reset();
        step(1, 1); step(0, 1); step(1, 1); step(0, 1);
        rst = 1'b0;
        #15;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m0 = '0;
        step(1, 1);
        chk("rst_mid_no_hit", 32'(m0[0]), 0);
        chk("rst_mid_cnt", 32'(cnt0), 0);
        step(0, 1); step(1, 1); step(0, 1); step(1, 1);
        chk("rst_mid_mask", 32'(m0[4:0]), 32'(5'b00001));
        chk("rst_mid_cnt2", 32'(cnt0), 1);

        // saturation of the 2-bit counter, then clear on a hit edge
        do_reset();
        step(1, 1);
        for (int k = 0; k < 6; k++) begin
            step(0, 1);
            step(1, 1);
        end
        chk("sat_cnt2", 32'(cnt2), 3);
        chk("sat_cnt8", 32'(cnt0), 5);
        step(0, 1);
        clr_cnt = 1'b1;
        step(1, 1);
        clr_cnt = 1'b0;
        chk("clr_out_fires", 32'(m0[0]), 1);
        chk("clr_cnt2", 32'(cnt2), 0);
        chk("clr_cnt8", 32'(cnt0), 0);
        step(0, 1); step(1, 1);
        chk("after_clr_cnt", 32'(cnt0), 1);
        step(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
